// File: rtl/rle_run_scheduler.sv
// Run-length scheduler: encodes a binary mask pixel stream into per-line run entries in a show-ahead FIFO.
// Defining RLE_LINE_HDR_EN adds a header entry {0, 0, line_idx} (run_hdr=1) ahead of each line's runs.
module rle_run_scheduler #(
    parameter int IMAGE_W = 640,
    parameter int LEN_W   = 10,
    parameter int FIFO_AW = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic             pix_bit,
    output logic             pix_ready,
    output logic             run_valid,
    input  logic             run_ready,
    output logic [LEN_W+1:0] run_data,
    output logic             run_hdr,
    output logic [LEN_W-1:0] line_idx,
    output logic             overflow,
    input  logic             clear_ovf,
    output logic [1:0]       dbg_state
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [LEN_W-1:0] LAST_COL = LEN_W'(IMAGE_W - 1);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_ENC   = 2'd1,
        S_FLUSH = 2'd2,
        S_HDR   = 2'd3
    } state_t;

`ifdef RLE_LINE_HDR_EN
    localparam state_t LINE_START = S_HDR;
    localparam int     ENT_W      = LEN_W + 3;
`else
    localparam state_t LINE_START = S_ENC;
    localparam int     ENT_W      = LEN_W + 2;
`endif

    // Both interfaces transfer on a rising edge where valid and ready are high together;
    // run_valid never depends on run_ready and pix_ready never depends on pix_valid.
    state_t              state_q, state_d;
    logic                pix_ready_q, pix_ready_d;
    logic [LEN_W-1:0]    tally_q, tally_d;
    logic                value_q, value_d;
    logic [LEN_W-1:0]    col_q, col_d;
    logic [LEN_W-1:0]    line_q, line_d;
    logic                ovf_q, ovf_d;
    logic [FIFO_AW:0]    count_q, count_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]    mem_q [DEPTH];

    logic                pix_acc, pop, full, wr_en, drop;
    logic                push_en, push_last, push_val;
    logic [LEN_W-1:0]    push_len;
    logic [ENT_W-1:0]    push_data, head;

`ifdef RLE_LINE_HDR_EN
    logic                push_hdr;
    assign push_data = {push_hdr, push_last, push_val, push_len};
    assign run_hdr   = run_valid & head[LEN_W+2];
`else
    assign push_data = {push_last, push_val, push_len};
    assign run_hdr   = 1'b0;
`endif

    assign head      = mem_q[rd_ptr_q];
    assign run_valid = (count_q != '0);
    assign run_data  = run_valid ? head[LEN_W+1:0] : '0;
    assign pix_ready = pix_ready_q;
    assign line_idx  = line_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        tally_d   = tally_q;
        value_d   = value_q;
        col_d     = col_q;
        line_d    = line_q;
        push_en   = 1'b0;
        push_last = 1'b0;
        push_val  = 1'b0;
        push_len  = '0;
`ifdef RLE_LINE_HDR_EN
        push_hdr  = 1'b0;
`endif
        pix_acc   = pix_valid & pix_ready_q;

        case (state_q)
            S_WAIT: begin
                if (pix_acc && frame_start) begin
                    line_d  = '0;
                    tally_d = ONE;
                    value_d = pix_bit;
                    col_d   = ONE;
                    state_d = LINE_START;
                end
            end
            S_ENC: begin
                if (pix_acc) begin
                    // A frame_start abandons the partial line; col==0 is the first pixel of a new line.
                    if (frame_start || col_q == '0) begin
                        if (frame_start) line_d = '0;
                        tally_d = ONE;
                        value_d = pix_bit;
                        col_d   = ONE;
                        state_d = LINE_START;
                    end else if (col_q == LAST_COL) begin
                        col_d   = '0;
                        push_en = 1'b1;
                        if (pix_bit == value_q) begin
                            push_last = 1'b1;
                            push_val  = value_q;
                            push_len  = tally_q + ONE;
                            line_d    = line_q + ONE;
                        end else begin
                            push_val = value_q;
                            push_len = tally_q;
                            value_d  = pix_bit;
                            state_d  = S_FLUSH;
                        end
                    end else if (pix_bit == value_q) begin
                        tally_d = tally_q + ONE;
                        col_d   = col_q + ONE;
                    end else begin
                        push_en  = 1'b1;
                        push_val = value_q;
                        push_len = tally_q;
                        tally_d  = ONE;
                        value_d  = pix_bit;
                        col_d    = col_q + ONE;
                    end
                end
            end
            S_FLUSH: begin
                // The line ended on a lone pixel of the opposite value; emit it as the closing run.
                push_en   = 1'b1;
                push_last = 1'b1;
                push_val  = value_q;
                push_len  = ONE;
                line_d    = line_q + ONE;
                state_d   = S_ENC;
            end
`ifdef RLE_LINE_HDR_EN
            S_HDR: begin
                push_en  = 1'b1;
                push_hdr = 1'b1;
                push_len = line_q;
                state_d  = S_ENC;
            end
`endif
            default: state_d = S_WAIT;
        endcase

        pix_ready_d = (state_d == S_WAIT) || (state_d == S_ENC);

        pop   = run_valid & run_ready;
        full  = (count_q == FULL_CNT);
        wr_en = push_en & (~full | pop);
        drop  = push_en & full & ~pop;

        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        // A drop in the same cycle as clear_ovf keeps the flag set.
        if (drop)           ovf_d = 1'b1;
        else if (clear_ovf) ovf_d = 1'b0;
        else                ovf_d = ovf_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= S_WAIT;
            pix_ready_q <= 1'b0;
            tally_q     <= '0;
            value_q     <= 1'b0;
            col_q       <= '0;
            line_q      <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            pix_ready_q <= pix_ready_d;
            tally_q     <= tally_d;
            value_q     <= value_d;
            col_q       <= col_d;
            line_q      <= line_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: tb/tb_rle_run_scheduler.sv
// Bench for rle_run_scheduler (IMAGE_W=8, FIFO_AW=2): line-level run model feeding an expected queue,
// one pop-time compare process, plus literal checks; also builds with RLE_LINE_HDR_EN defined.
module tb_rle_run_scheduler;
    localparam int IMAGE_W = 8;
    localparam int LEN_W   = 10;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int LINES   = 2 ** LEN_W;
    localparam int EW      = LEN_W + 3;
`ifdef RLE_LINE_HDR_EN
    localparam int HDR_N = 1;
`else
    localparam int HDR_N = 0;
`endif

    logic             CLK;
    logic             RESET_N;
    logic             frame_start;
    logic             pix_valid;
    logic             pix_bit;
    logic             pix_ready;
    logic             run_valid;
    logic             run_ready;
    logic [LEN_W+1:0] run_data;
    logic             run_hdr;
    logic [LEN_W-1:0] line_idx;
    logic             overflow;
    logic             clear_ovf;
    logic [1:0]       dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_line     = 0;
    logic [EW-1:0] exp_q[$];

    rle_run_scheduler #(.IMAGE_W(IMAGE_W), .LEN_W(LEN_W), .FIFO_AW(FIFO_AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_bit(pix_bit), .pix_ready(pix_ready), .run_valid(run_valid), .run_ready(run_ready),
        .run_data(run_data), .run_hdr(run_hdr), .line_idx(line_idx), .overflow(overflow),
        .clear_ovf(clear_ovf), .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every popped entry must be the next expected one
    always @(negedge CLK) begin
        if (RESET_N && run_valid && run_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_entry", {run_hdr, run_data}, '0);
            end else begin
                check("run_entry", {run_hdr, run_data}, exp_q.pop_front());
            end
        end
    end

    // line model: run-length encode a whole line, keep entries with index in [skip, keep)
    task automatic model_line(input logic [IMAGE_W-1:0] px, input int skip, input int keep);
        logic [EW-1:0] ents[$];
        int run;
        ents = {};
`ifdef RLE_LINE_HDR_EN
        ents.push_back({1'b1, 1'b0, 1'b0, LEN_W'(exp_line)});
`endif
        run = 1;
        for (int k = 1; k < IMAGE_W; k++) begin
            if (px[IMAGE_W-1-k] == px[IMAGE_W-k]) begin
                run++;
            end else begin
                ents.push_back({1'b0, 1'b0, px[IMAGE_W-k], LEN_W'(run)});
                run = 1;
            end
        end
        ents.push_back({1'b0, 1'b1, px[0], LEN_W'(run)});
        for (int i = skip; i < ents.size() && i < keep; i++) exp_q.push_back(ents[i]);
    endtask

    task automatic exp_ent(input logic last, input logic val, input int len);
        exp_q.push_back({1'b0, last, val, LEN_W'(len)});
    endtask

    task automatic exp_hdr(input int idx);
`ifdef RLE_LINE_HDR_EN
        exp_q.push_back({1'b1, 1'b0, 1'b0, LEN_W'(idx)});
`else
        if (idx < 0) exp_q.delete();
`endif
    endtask

    // driver: present one pixel at a negedge, hold until accepted, return stall cycles
    task automatic send_pix(input logic b, input logic fs, input logic clr, output int stalls);
        int guard;
        @(negedge CLK);
        pix_valid = 1'b1;
        pix_bit = b;
        frame_start = fs;
        clear_ovf = clr;
        stalls = 0;
        guard = 0;
        while (!pix_ready && guard < 50) begin
            @(negedge CLK);
            stalls++;
            guard++;
        end
        if (!pix_ready) check("pix_ready_timeout", 64'(pix_ready), 64'd1);
        @(posedge CLK);
        #1;
        pix_valid = 1'b0;
        frame_start = 1'b0;
        clear_ovf = 1'b0;
    endtask

    // px is written first pixel leftmost (bit IMAGE_W-1)
    task automatic drive_line(input logic [IMAGE_W-1:0] px, input bit fs, input bit use_model,
                              input int skip, input int keep, output int stall0);
        int st;
        if (fs) exp_line = 0;
        if (use_model) model_line(px, skip, keep);
        exp_line = (exp_line + 1) % LINES;
        stall0 = 0;
        for (int k = 0; k < IMAGE_W; k++) begin
            send_pix(px[IMAGE_W-1-k], (k == 0) ? fs : 1'b0, 1'b0, st);
            if (k == 0) stall0 = st;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        repeat (2) @(negedge CLK);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int st;
        logic [IMAGE_W-1:0] px2;
        RESET_N = 1'b0;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        pix_bit = 1'b0;
        run_ready = 1'b1;
        clear_ovf = 1'b0;

        // reset values
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(negedge CLK);
        check("rst_pix_ready", 64'(pix_ready), 64'd0);
        check("rst_run_valid", 64'(run_valid), 64'd0);
        check("rst_run_data", 64'(run_data), 64'd0);
        check("rst_run_hdr", 64'(run_hdr), 64'd0);
        check("rst_line_idx", 64'(line_idx), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        @(negedge CLK);
        check("pix_ready_after_rst", 64'(pix_ready), 64'd1);

        // pixels before any frame_start are discarded
        send_pix(1'b1, 1'b0, 1'b0, st);
        send_pix(1'b0, 1'b0, 1'b0, st);
        send_pix(1'b1, 1'b0, 1'b0, st);
        repeat (3) @(negedge CLK);
        check("wait_discard_valid", 64'(run_valid), 64'd0);
        check("wait_discard_line", 64'(line_idx), 64'd0);

        // line 0: 00111000
        exp_hdr(0);
        exp_ent(1'b0, 1'b0, 2);
        exp_ent(1'b0, 1'b1, 3);
        exp_ent(1'b1, 1'b0, 3);
        drive_line(8'b00111000, 1'b1, 1'b0, 0, 100, st);
        wait_drain();
        check("line_idx_after_l0", 64'(line_idx), 64'd1);

        // line 1: 11111110 ends on a lone pixel, so the next line's first pixel sees one stall
        exp_hdr(1);
        exp_ent(1'b0, 1'b1, 7);
        exp_ent(1'b1, 1'b0, 1);
        drive_line(8'b11111110, 1'b0, 1'b0, 0, 100, st);
        drive_line(8'b10110010, 1'b0, 1'b1, 0, 100, st);
        check("flush_stall", 64'(st), 64'd1);
        wait_drain();
        check("line_idx_after_l2", 64'(line_idx), 64'd3);

        // frame_start after 5 pixels of a line: partial run discarded, new frame at line 0
        for (int k = 0; k < 5; k++) send_pix(1'b1, 1'b0, 1'b0, st);
        @(negedge CLK);
        check("partial_no_entry", 64'(run_valid), 64'd0);
        check("partial_line_idx", 64'(line_idx), 64'd3);
        drive_line(8'b11000111, 1'b1, 1'b1, 0, 100, st);
        wait_drain();
        check("restart_line_idx", 64'(line_idx), 64'd1);
        check("no_ovf_yet", 64'(overflow), 64'd0);

        // overflow: consumer stalled, only DEPTH entries survive
        run_ready = 1'b0;
        drive_line(8'b01010101, 1'b0, 1'b1, 0, DEPTH, st);
        repeat (3) @(negedge CLK);
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_fifo_valid", 64'(run_valid), 64'd1);

        // next line: clear_ovf lands on a dropping push, then a push coincides with a pop while full
        px2 = 8'b01011001;
        model_line(px2, 1 + HDR_N, 100);
        exp_line = (exp_line + 1) % LINES;
        for (int k = 0; k < IMAGE_W; k++) begin
            send_pix(px2[IMAGE_W-1-k], 1'b0, (k == 1) ? 1'b1 : 1'b0, st);
            if (k == 1) run_ready = 1'b1;
            if (k == 2) begin
                @(negedge CLK);
                check("ovf_set_wins", 64'(overflow), 64'd1);
            end
        end
        wait_drain();
        clear_ovf = 1'b1;
        @(posedge CLK);
        #1;
        clear_ovf = 1'b0;
        @(negedge CLK);
        check("ovf_cleared", 64'(overflow), 64'd0);
        check("fifo_empty_after_ovf", 64'(run_valid), 64'd0);
        check("line_idx_after_ovf", 64'(line_idx), 64'd3);

        // reset mid-operation with entries queued
        run_ready = 1'b0;
        drive_line(8'b00111000, 1'b1, 1'b1, 0, 0, st);
        repeat (2) @(negedge CLK);
        check("pre_rst_valid", 64'(run_valid), 64'd1);
        check("pre_rst_line", 64'(line_idx), 64'd1);
        @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        exp_line = 0;
        @(negedge CLK);
        check("mid_rst_pix_ready", 64'(pix_ready), 64'd0);
        check("mid_rst_valid", 64'(run_valid), 64'd0);
        check("mid_rst_line", 64'(line_idx), 64'd0);
        check("mid_rst_ovf", 64'(overflow), 64'd0);
        run_ready = 1'b1;
        send_pix(1'b0, 1'b0, 1'b0, st);
        send_pix(1'b1, 1'b0, 1'b0, st);
        send_pix(1'b1, 1'b0, 1'b0, st);
        repeat (4) @(negedge CLK);
        check("post_rst_discard", 64'(run_valid), 64'd0);
        check("post_rst_line", 64'(line_idx), 64'd0);
        drive_line(8'b10000001, 1'b1, 1'b1, 0, 100, st);
        wait_drain();
        check("post_rst_encode_line", 64'(line_idx), 64'd1);

        // many lines of varied patterns, through the line_idx wrap
        for (int i = 0; i < LINES - 2; i++) begin
            drive_line(8'(i * 37 + 11), 1'b0, 1'b1, 0, 100, st);
        end
        wait_drain();
        check("line_idx_max", 64'(line_idx), 64'(LINES - 1));
        drive_line(8'b11110000, 1'b0, 1'b1, 0, 100, st);
        wait_drain();
        check("line_idx_wrap", 64'(line_idx), 64'd0);
        check("no_ovf_streaming", 64'(overflow), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/rle_run_scheduler.md
Name: rle_run_scheduler

Overview:
- Sequences binary mask pixels (colour-threshold output) into per-line run-length entries.
- Buffers entries in an internal FIFO and hands them to the downstream packetiser/UART bridge over a valid/ready handshake.
- Replaces fixed-three-streak encoding: every run of every line is emitted, with explicit line framing and overflow reporting.

Parameters:
- IMAGE_W, 640, pixels per line; range 2..1023.
- LEN_W, 10, run-length and line-index field width.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  synchronous, active-low reset.
- frame_start  in  1  marks the first pixel of a frame; qualified by pix_valid&pix_ready.
- pix_valid  in  1  pixel present.
- pix_bit  in  1  mask pixel value.
- pix_ready  out  1  block accepts a pixel this cycle.
- run_valid  out  1  FIFO head valid.
- run_ready  in  1  consumer takes head.
- run_data  out  LEN_W+2  {last, value, len}.
- run_hdr  out  1  head is a line header (feature only; else tied 0).
- line_idx  out  LEN_W  current line number within frame.
- overflow  out  1  sticky: an entry was dropped on full FIFO.
- clear_ovf  in  1  one-cycle pulse clears overflow.

Behaviour:
- Pixel accepted when pix_valid&pix_ready. Consumer handshake: pop when run_valid&run_ready.
- Reset values: pix_ready=0 for the reset cycle, then 1. run_valid=0, run_data=0, run_hdr=0, line_idx=0, overflow=0. FIFO empty; internal tally=0, col=0; state WAIT.
- Reset mid-operation flushes the FIFO and discards any partial run.
- WAIT: pixels without frame_start are accepted and discarded. An accepted pixel with frame_start starts line 0: tally=1, value=pix_bit, col=1, state ENC.
- ENC, accepted pixel not the last in line, same value: tally+1.
- ENC, accepted pixel not the last in line, different value: push {0, prev value, tally}; tally=1, value=pix_bit.
- ENC, last pixel of line (col==IMAGE_W-1), same value: push {1, value, tally+1}. Then col=0, line_idx+1, stay ENC.
- ENC, last pixel of line, different value: push {0, prev, tally}, go FLUSH.
- FLUSH: pix_ready=0. Push {1, pix_bit_latched, 1}, line_idx+1, return to ENC. Lasts exactly one cycle.
- The first pixel of each subsequent line starts a fresh run; runs never span lines.
- frame_start accepted in ENC: abandon the current line without pushing a partial run. line_idx=0; the pixel becomes pixel 0 of line 0.
- line_idx wraps modulo 2**LEN_W.
- FIFO: show-ahead. A pushed entry appears at run_data the cycle after the push.
- Push and pop in the same cycle are both honoured, including when the FIFO is full: the pop frees the slot.
- Push into a full FIFO with no simultaneous pop: the entry is dropped and overflow is set the next cycle.
- clear_ovf coincident with a drop: overflow stays 1 (set wins).
- Invariant: the sum of len over one line's entries equals IMAGE_W; exactly one entry per line has last=1.

Optional Feature:
- Macro RLE_LINE_HDR_EN.
- Defined: at the start of each line (the cycle after that line's first pixel is accepted), state HDR pushes {0, 0, line_idx} with run_hdr=1 on that entry. pix_ready=0 during HDR (one cycle). The header precedes that line's runs in the FIFO.
- Undefined: no HDR state; run_hdr tied 0; pix_ready drops only in FLUSH.

Test Plan:
- IMAGE_W=8, line 0 pixels 00111000 after frame_start, run_ready=1 → entries {0,0,2},{0,1,3},{1,0,3}; line_idx becomes 1.
- IMAGE_W=8, pixels 11111110 → {0,1,7} then, after one FLUSH cycle with pix_ready=0, {1,0,1}.
- IMAGE_W=8, FIFO_AW=2, run_ready=0, line 01010101 → first 4 entries kept, remaining 4 dropped, overflow=1. clear_ovf pulse → overflow=0.
- frame_start asserted at pixel 5 of a line after 5 pixels of 1 → no entry for the partial run; line_idx=0; the new line is encoded normally.
- RESET_N low for 1 cycle with 3 entries queued → run_valid=0, line_idx=0, overflow=0; following pixels without frame_start are discarded.
- RLE_LINE_HDR_EN defined, two lines of all-ones, IMAGE_W=8 → hdr(0),{1,1,8},hdr(1),{1,1,8}, with run_hdr=1 only on the header entries.
